i2c_master_burst: RTL and testbench
===================================

I2C_MASTER_BURST -- requirements
Module: i2c_master_burst

Interface
REQ-001 Parameter: CLK_DIV, default 250, i_clk cycles per SCL quarter-period (100 kHz SCL at 100 MHz i_clk); SHALL be >= 2.
REQ-002 Parameter: MAX_LEN, default 16, maximum data bytes per transfer; LEN_W = clog2(MAX_LEN+1) SHALL be derived, not overridable.
REQ-003 i_clk  in  1  system clock; all logic SHALL be on its rising edge.
REQ-004 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 i_start  in  1  transfer request, sampled only in IDLE.
REQ-006 i_addr  in  7  7-bit slave address.
REQ-007 i_rw  in  1  direction: 0 write, 1 read.
REQ-008 i_len  in  LEN_W  data byte count, 0..MAX_LEN; 0 = address-only probe.
REQ-009 i_wdata  in  8  write byte, sampled in the cycle o_wready=1.
REQ-010 o_wready  out  1  one-cycle pulse: i_wdata consumed.
REQ-011 o_rdata  out  8  received byte, valid while o_rvalid=1.
REQ-012 o_rvalid  out  1  one-cycle pulse per received byte.
REQ-013 o_busy  out  1  high from the cycle after an accepted i_start through the o_done cycle.
REQ-014 o_done  out  1  one-cycle pulse at end of transfer.
REQ-015 o_nack  out  1  slave NACK seen; valid with o_done, held until next accepted i_start.
REQ-016 o_scl_oe  out  1  1 = pull SCL low, 0 = release (open drain).
REQ-017 o_sda_oe  out  1  1 = pull SDA low, 0 = release.
REQ-018 i_sda  in  1  SDA line level (externally synchronised).

Function
REQ-019 Quarter tick SHALL occur every CLK_DIV cycles while busy; each bit-time SHALL be 4 quarters: Q0 SCL low/drive SDA, Q1-Q2 SCL released, sample i_sda at end of Q1, Q3 SCL low.
REQ-020 FSM states SHALL be IDLE, START, ADDR, ADDR_ACK, WRITE, W_ACK, READ, M_ACK, STOP.
REQ-021 IDLE: both oe=0; i_start=1 latches i_addr, i_rw, i_len and enters START; i_start while busy SHALL be ignored.
REQ-022 i_len > MAX_LEN SHALL be clamped to MAX_LEN.
REQ-023 START (1 bit-time): SDA pulled low while SCL released, then SCL pulled low.
REQ-024 ADDR: 8 bits {i_addr, i_rw}, MSB first; then ADDR_ACK samples i_sda with SDA released.
REQ-025 ADDR_ACK: i_sda=1 -> o_nack=1, STOP; i_sda=0 and len=0 -> STOP; else WRITE (i_rw=0) or READ (i_rw=1).
REQ-026 WRITE: o_wready pulses on the first cycle of the byte; 8 bits MSB first; then W_ACK.
REQ-027 W_ACK: i_sda=1 -> o_nack=1, STOP (remaining bytes abandoned); else decrement count, WRITE if count>0, else STOP.
REQ-028 READ: SDA released, 8 bits sampled MSB first; o_rvalid pulses with o_rdata in the cycle after the 8th sample; then M_ACK.
REQ-029 M_ACK: master drives ACK (SDA low) if bytes remain, NACK (release) on the last byte; then READ or STOP.
REQ-030 STOP (1 bit-time): SDA low with SCL low, release SCL, then release SDA; o_done pulses the cycle after, then IDLE.
REQ-031 Transfer latency, no NACK: o_done SHALL assert 4*CLK_DIV*(2 + 9*(1+len)) cycles after the i_start cycle, +1.
REQ-032 No clock stretching or arbitration; SCL input is not monitored.

Reset
REQ-033 Reset SHALL force IDLE, o_scl_oe=0, o_sda_oe=0, o_busy=0, o_done=0, o_nack=0, o_wready=0, o_rvalid=0, o_rdata=0, counters 0.
REQ-034 Reset mid-transfer SHALL release both lines immediately (asynchronously); no STOP is generated.

Structure
REQ-035 Shared package i2c_pkg SHALL hold the state enum, the quarter-phase encoding and the address/data width constants.
REQ-036 Sub-module i2c_bit_timer SHALL generate the quarter tick and 2-bit phase from CLK_DIV, enabled by busy.

Verification (CLK_DIV=4 unless stated)
REQ-037 Write addr 0x50, len 2, data 0xA5,0x3C, slave ACKs -> SDA bytes 0xA0,0xA5,0x3C; 2 o_wready pulses; o_done at cycle 465; o_nack=0.
REQ-038 Read addr 0x1D, len 3, slave returns 0x11,0x22,0x33 -> 3 o_rvalid pulses with those values; master ACK,ACK,NACK; o_nack=0.
REQ-039 Address NACK on addr 0x7F write len 4 -> o_nack=1, STOP follows ADDR_ACK, zero o_wready pulses, o_done at cycle 177.
REQ-040 Probe len 0, ACK -> START, 0x(addr<<1), ACK, STOP; o_done at cycle 177; o_nack=0.
REQ-041 Data NACK on 2nd of 4 write bytes -> o_nack=1, exactly 2 o_wready pulses, STOP after W_ACK.
REQ-042 i_rst_n low mid-ADDR, and i_start pulsed while busy -> oe=0 within reset; the busy-time i_start produces no second transfer.

Source files
------------

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state, quarter-phase and width definitions for the burst I2C master.
package i2c_pkg;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  typedef enum logic [3:0] {
    IDLE, START, ADDR, ADDR_ACK, WRITE, W_ACK, READ, M_ACK, STOP
  } state_e;
  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} phase_e;
endpackage

// File: rtl/i2c_bit_timer.sv
// i2c_bit_timer: quarter-period tick and phase generator, held at Q0 while disabled.
module i2c_bit_timer
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 250
) (
  input  logic   i_clk,
  input  logic   i_rst_n,
  input  logic   en_i,
  output logic   tick_o,
  output logic   first_o,
  output phase_e phase_o
);
  localparam int CW = $clog2(CLK_DIV);
  logic [CW-1:0] cnt_q, cnt_d;
  phase_e phase_q, phase_d;
  always_comb begin
    tick_o = en_i && cnt_q == CW'(CLK_DIV - 1);
    first_o = cnt_q == '0;
    cnt_d = (!en_i || tick_o) ? '0 : cnt_q + CW'(1);
    phase_d = !en_i ? Q0 : tick_o ? phase_e'(phase_q + 2'd1) : phase_q;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      cnt_q <= '0;
      phase_q <= Q0;
    end else begin
      cnt_q <= cnt_d;
      phase_q <= phase_d;
    end
  assign phase_o = phase_q;
endmodule

// File: rtl/i2c_master_burst.sv
// i2c_master_burst: I2C master issuing START, address, a burst of up to MAX_LEN data bytes and STOP.
module i2c_master_burst
  import i2c_pkg::*;
#(
  parameter  int CLK_DIV = 250,
  parameter  int MAX_LEN = 16,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_rw,
  input  logic [LEN_W-1:0]  i_len,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_wready,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_rvalid,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_nack,
  output logic              o_scl_oe,
  output logic              o_sda_oe,
  input  logic              i_sda
);
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);
  state_e state_q, state_d;
  logic [2:0] bit_q, bit_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [DATA_W-1:0] sh_q, sh_d, rdata_q, rdata_d;
  logic rw_q, rw_d, ack_q, ack_d, nack_q, nack_d, done_q, done_d, rvalid_q, rvalid_d;
  logic tick, first, sample, bend, dscl;
  phase_e phase;
  i2c_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .en_i   (state_q != IDLE),
    .tick_o (tick),
    .first_o(first),
    .phase_o(phase)
  );
  always_comb begin
    sample = tick && phase == Q1;
    bend = tick && phase == Q3;
    dscl = phase == Q0 || phase == Q3;
    state_d = state_q;
    bit_d = bit_q;
    len_d = len_q;
    sh_d = sh_q;
    rw_d = rw_q;
    ack_d = ack_q;
    nack_d = nack_q;
    done_d = 1'b0;
    rvalid_d = 1'b0;
    rdata_d = rdata_q;
    o_scl_oe = 1'b0;
    o_sda_oe = 1'b0;
    o_wready = 1'b0;
    case (state_q)
      IDLE: if (i_start && !done_q) begin
        state_d = START;
        rw_d = i_rw;
        sh_d = {i_addr, i_rw};
        len_d = (i_len > MAX_L) ? MAX_L : i_len;
        nack_d = 1'b0;
        bit_d = '0;
      end
      START: begin
        o_scl_oe = phase == Q3;
        o_sda_oe = phase != Q0;
        if (bend) state_d = ADDR;
      end
      ADDR: begin
        o_scl_oe = dscl;
        o_sda_oe = !sh_q[7];
        if (bend) begin
          sh_d = {sh_q[6:0], 1'b0};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = ADDR_ACK;
        end
      end
      ADDR_ACK: begin
        o_scl_oe = dscl;
        if (sample) ack_d = i_sda;
        if (bend) begin
          nack_d = ack_q;
          state_d = (ack_q || len_q == '0) ? STOP : rw_q ? READ : WRITE;
        end
      end
      WRITE: begin
        o_scl_oe = dscl;
        // the first byte bit goes out straight from i_wdata while it is being captured
        o_wready = bit_q == '0 && phase == Q0 && first;
        o_sda_oe = !(o_wready ? i_wdata[7] : sh_q[7]);
        if (o_wready) sh_d = i_wdata;
        if (bend) begin
          sh_d = {sh_q[6:0], 1'b0};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = W_ACK;
        end
      end
      W_ACK: begin
        o_scl_oe = dscl;
        if (sample) ack_d = i_sda;
        if (bend) begin
          nack_d = ack_q;
          len_d = len_q - LEN_W'(1);
          state_d = (!ack_q && len_q > LEN_W'(1)) ? WRITE : STOP;
        end
      end
      READ: begin
        o_scl_oe = dscl;
        if (sample) begin
          sh_d = {sh_q[6:0], i_sda};
          rvalid_d = bit_q == 3'd7;
          rdata_d = (bit_q == 3'd7) ? {sh_q[6:0], i_sda} : rdata_q;
        end
        if (bend) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = M_ACK;
        end
      end
      M_ACK: begin
        o_scl_oe = dscl;
        o_sda_oe = len_q > LEN_W'(1);
        if (bend) begin
          len_d = len_q - LEN_W'(1);
          state_d = (len_q > LEN_W'(1)) ? READ : STOP;
        end
      end
      STOP: begin
        o_scl_oe = phase == Q0;
        o_sda_oe = phase == Q0 || phase == Q1;
        if (bend) begin
          state_d = IDLE;
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q <= IDLE;
      bit_q <= '0;
      len_q <= '0;
      sh_q <= '0;
      rw_q <= 1'b0;
      ack_q <= 1'b0;
      nack_q <= 1'b0;
      done_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      bit_q <= bit_d;
      len_q <= len_d;
      sh_q <= sh_d;
      rw_q <= rw_d;
      ack_q <= ack_d;
      nack_q <= nack_d;
      done_q <= done_d;
      rvalid_q <= rvalid_d;
      rdata_q <= rdata_d;
    end
  assign o_busy = state_q != IDLE || done_q;
  assign o_done = done_q;
  assign o_nack = nack_q;
  assign o_rvalid = rvalid_q;
  assign o_rdata = rdata_q;
endmodule

// File: tb/tb_i2c_master_burst.sv
// tb_i2c_master_burst: bus-level slave model and transfer scoreboard for i2c_master_burst.
module tb_i2c_master_burst;
  localparam int CD = 4;
  localparam int ML = 16;
  logic i_clk = 1'b0, i_rst_n = 1'b0, i_start = 1'b0, i_rw = 1'b0;
  logic [6:0] i_addr = '0;
  logic [4:0] i_len = '0;
  logic [7:0] i_wdata, o_rdata;
  logic o_wready, o_rvalid, o_busy, o_done, o_nack, o_scl_oe, o_sda_oe, i_sda;

  typedef struct {
    logic rw; logic [6:0] addr; int len; logic ack; int nack_byte;
    logic [19:0][7:0] dat; int exp_done; logic exp_nack;
  } vec_t;
  vec_t tbl[12];

  int nvec = 0, nmis = 0;
  logic s_rw = 0, s_ack = 1;
  int s_nack = 0, s_len = 0;
  logic [19:0][7:0] s_dat = '0;

  logic pull = 1'b0, pscl = 1'b1, psda = 1'b1, xfer = 1'b0, wprev = 1'b0;
  logic [7:0] sh = '0;
  int r = 0, k = 0, n_start = 0, n_stop = 0, n_wr = 0, widx = 0, wbase = 0, wi;
  logic [8:0] bus_q[$];
  logic [7:0] rd_q[$];
  logic scl_b, sda_b;

  i2c_master_burst #(.CLK_DIV(CD), .MAX_LEN(ML)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_addr(i_addr), .i_rw(i_rw),
    .i_len(i_len), .i_wdata(i_wdata), .o_wready(o_wready), .o_rdata(o_rdata),
    .o_rvalid(o_rvalid), .o_busy(o_busy), .o_done(o_done), .o_nack(o_nack),
    .o_scl_oe(o_scl_oe), .o_sda_oe(o_sda_oe), .i_sda(i_sda)
  );

  always #5 i_clk = ~i_clk;
  assign scl_b = ~o_scl_oe;
  assign sda_b = ~(o_sda_oe | pull);
  assign i_sda = sda_b;
  assign wi = widx - wbase;
  assign i_wdata = (wi >= 0 && wi < 20) ? s_dat[wi] : 8'h00;

  function automatic logic slave_pull(input int kk, input int rr);
    logic [7:0] b;
    if (rr == 8) return (kk == 0) ? s_ack : (!s_rw && kk != s_nack);
    if (kk >= 1 && s_rw && s_ack && kk <= s_len) begin
      b = s_dat[kk-1];
      return ~b[7-rr];
    end
    return 1'b0;
  endfunction

  // open-drain slave: decodes START/STOP and bytes, answers ACKs and read data on SCL falls
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      pull = 0; r = 0; k = 0; xfer = 0; wprev = 0; pscl = 1; psda = 1;
    end else begin
      if (scl_b && pscl && psda && !sda_b) begin n_start++; r = 0; k = 0; xfer = 1; end
      if (scl_b && pscl && !psda && sda_b) begin n_stop++; xfer = 0; pull = 0; end
      if (xfer && scl_b && !pscl) begin
        if (r < 8) sh = {sh[6:0], sda_b};
        else bus_q.push_back({sda_b, sh});
        r++;
      end
      if (xfer && !scl_b && pscl) begin
        if (r == 9) begin r = 0; k++; end
        pull = slave_pull(k, r);
      end
      if (wprev) widx++;
      wprev = o_wready;
      if (o_wready) n_wr++;
      if (o_rvalid) rd_q.push_back(o_rdata);
      pscl = scl_b;
      psda = sda_b;
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int wire_bytes(input vec_t v);
    int eff = (v.len > ML) ? ML : v.len;
    if (!v.ack) return 0;
    if (!v.rw && v.nack_byte >= 1 && v.nack_byte <= eff) return v.nack_byte;
    return eff;
  endfunction

  function automatic logic model_nack(input vec_t v);
    int eff = (v.len > ML) ? ML : v.len;
    return !v.ack || (!v.rw && v.nack_byte >= 1 && v.nack_byte <= eff);
  endfunction

  task automatic run(input vec_t v, input int idx);
    int bb, br, bw, ns, np, cyc, w;
    logic [8:0] exp_b;
    w = wire_bytes(v);
    s_rw = v.rw; s_ack = v.ack; s_nack = v.nack_byte; s_dat = v.dat;
    s_len = (v.len > ML) ? ML : v.len;
    bb = bus_q.size(); br = rd_q.size(); bw = n_wr; ns = n_start; np = n_stop; wbase = widx;
    @(negedge i_clk);
    i_addr = v.addr; i_rw = v.rw; i_len = 5'(v.len); i_start = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    @(negedge i_clk);
    cyc = 1;
    check($sformatf("v%0d busy", idx), o_busy, 1);
    check($sformatf("v%0d nack_clear", idx), o_nack, 0);
    while (!o_done && cyc < 5000) begin @(negedge i_clk); cyc++; end
    check($sformatf("v%0d done_cycle", idx), cyc, v.exp_done);
    check($sformatf("v%0d nack", idx), o_nack, v.exp_nack);
    @(negedge i_clk);
    check($sformatf("v%0d done_pulse", idx), o_done, 0);
    check($sformatf("v%0d idle", idx), o_busy, 0);
    check($sformatf("v%0d starts", idx), n_start - ns, 1);
    check($sformatf("v%0d stops", idx), n_stop - np, 1);
    check($sformatf("v%0d bytes", idx), bus_q.size() - bb, 1 + w);
    for (int i = 0; i <= w && bb + i < bus_q.size(); i++) begin
      if (i == 0) exp_b = {!v.ack, v.addr, v.rw};
      else if (v.rw) exp_b = {i == w, v.dat[i-1]};
      else exp_b = {i == v.nack_byte, v.dat[i-1]};
      check($sformatf("v%0d byte%0d", idx, i), bus_q[bb+i], exp_b);
    end
    check($sformatf("v%0d wready", idx), n_wr - bw, v.rw ? 0 : w);
    check($sformatf("v%0d rvalid", idx), rd_q.size() - br, v.rw ? w : 0);
    for (int i = 0; v.rw && i < w && br + i < rd_q.size(); i++)
      check($sformatf("v%0d rdata%0d", idx, i), rd_q[br+i], v.dat[i]);
    repeat (5) @(negedge i_clk);
    check($sformatf("v%0d nack_hold", idx), o_nack, v.exp_nack);
  endtask

  initial begin
    int cyc, dc, busy_after, ns, nd;
    for (int i = 0; i < 12; i++) begin
      tbl[i].rw = 0; tbl[i].addr = 0; tbl[i].len = 0; tbl[i].ack = 1; tbl[i].nack_byte = 0;
      for (int j = 0; j < 20; j++) tbl[i].dat[j] = 8'($urandom);
    end
    tbl[0].addr = 7'h50; tbl[0].len = 2; tbl[0].dat[0] = 8'hA5; tbl[0].dat[1] = 8'h3C;
    tbl[0].exp_done = 465; tbl[0].exp_nack = 0;
    tbl[1].rw = 1; tbl[1].addr = 7'h1D; tbl[1].len = 3;
    tbl[1].dat[0] = 8'h11; tbl[1].dat[1] = 8'h22; tbl[1].dat[2] = 8'h33;
    tbl[1].exp_done = 609; tbl[1].exp_nack = 0;
    tbl[2].addr = 7'h7F; tbl[2].len = 4; tbl[2].ack = 0; tbl[2].exp_done = 177; tbl[2].exp_nack = 1;
    tbl[3].addr = 7'h2A; tbl[3].exp_done = 177; tbl[3].exp_nack = 0;
    tbl[4].addr = 7'h33; tbl[4].len = 4; tbl[4].nack_byte = 2; tbl[4].exp_done = 465; tbl[4].exp_nack = 1;
    tbl[5].addr = 7'h44; tbl[5].len = 20; tbl[5].exp_done = 2481; tbl[5].exp_nack = 0;
    for (int i = 6; i < 12; i++) begin
      tbl[i].rw = 1'($urandom_range(0, 1));
      tbl[i].addr = 7'($urandom);
      tbl[i].len = $urandom_range(0, 5);
      tbl[i].ack = $urandom_range(0, 4) != 0;
      tbl[i].nack_byte = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : 0;
      tbl[i].exp_done = 4 * CD * (2 + 9 * (1 + wire_bytes(tbl[i]))) + 1;
      tbl[i].exp_nack = model_nack(tbl[i]);
    end

    repeat (3) @(negedge i_clk);
    check("rst_scl", o_scl_oe, 0); check("rst_sda", o_sda_oe, 0); check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0); check("rst_nack", o_nack, 0); check("rst_wready", o_wready, 0);
    check("rst_rvalid", o_rvalid, 0); check("rst_rdata", o_rdata, 0);
    i_rst_n = 1'b1;
    repeat (3) @(negedge i_clk);

    for (int i = 0; i < 12; i++) run(tbl[i], i);

    // start requests during the transfer and in its done cycle must be ignored
    s_rw = 0; s_ack = 1; s_nack = 0; s_len = 0;
    ns = n_start; nd = 0; dc = 100000; busy_after = 0;
    @(negedge i_clk);
    i_addr = 7'h2A; i_rw = 0; i_len = 0; i_start = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    for (cyc = 1; cyc <= 600; cyc++) begin
      @(negedge i_clk);
      if (o_done) begin dc = cyc; nd++; end
      if (cyc > dc && o_busy) busy_after++;
      i_addr = 7'h11;
      i_start = (cyc == 60) || o_done;
    end
    i_start = 1'b0;
    check("ign_done_cycle", dc, 177);
    check("ign_done_count", nd, 1);
    check("ign_busy_after", busy_after, 0);
    check("ign_starts", n_start - ns, 1);

    // asynchronous reset in the middle of the address byte
    s_ack = 1;
    @(negedge i_clk);
    i_addr = 7'h00; i_rw = 0; i_len = 1; i_start = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    repeat (40) @(negedge i_clk);
    check("pre_rst_sda", o_sda_oe, 1);
    check("pre_rst_busy", o_busy, 1);
    #2 i_rst_n = 1'b0;
    #1;
    check("async_rst_sda", o_sda_oe, 0);
    check("async_rst_scl", o_scl_oe, 0);
    check("async_rst_busy", o_busy, 0);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    nd = 0; busy_after = 0;
    repeat (300) begin
      @(negedge i_clk);
      if (o_done) nd++;
      if (o_busy || o_scl_oe || o_sda_oe) busy_after++;
    end
    check("post_rst_done", nd, 0);
    check("post_rst_active", busy_after, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
